remote_update_seq: RTL and testbench
====================================

// Module: remote_update_seq
// PURPOSE
//  Command-driven sequencer for the Cyclone remote-update core. Generalises the fixed
//  factory->application boot step: programmable boot address, optional watchdog
//  programming, parameter readback and busy-timeout error reporting. Sits beside
//  the remote-update core instance; commands come from the protocol/control path.
// PARAMETERS
//  BOOT_ADDR   24'h040000  boot address (param 3'b100) used by AUTO_BOOT and op 0 when cmd_addr==0
//  AUTO_BOOT   1           1: run BOOT sequence once after reset, reconfig only if bootapp=1
//  WD_EN       0           1: BOOT also writes watchdog timeout (3'b010) and enable (3'b011)
//  WD_TIMEOUT  12'h100     watchdog timeout value, zero-extended to 24 bits
//  BUSY_TO     1023        max clk cycles per busy wait (rise or fall) before error
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous reset, active-high
//  bootapp      in   1   level; gates ru_reconfig at end of BOOT
//  cmd_valid    in   1   command request
//  cmd_ready    out  1   1 only in IDLE; accept on cmd_valid&cmd_ready
//  cmd_op       in   2   0=BOOT, 1=READ_PARAM, 2=WD_KICK, 3=ABORT_RESET(no-op, rsp ok)
//  cmd_param    in   3   param select for READ_PARAM
//  cmd_addr     in   24  boot address for BOOT (0 -> BOOT_ADDR)
//  rsp_valid    out  1   one-cycle pulse, command finished
//  rsp_err      out  1   valid with rsp_valid; 1 = busy timeout
//  rsp_data     out  24  READ_PARAM result, else 0; held until next rsp_valid
//  ru_param     out  3   to core param
//  ru_data_in   out  24  to core data_in
//  ru_write     out  1   to core write_param
//  ru_read      out  1   to core read_param
//  ru_reconfig  out  1   to core reconfig
//  ru_rst_timer out  1   to core reset_timer
//  ru_busy      in   1   from core busy
//  ru_data_out  in   24  from core data_out
// BEHAVIOUR
//  Reset: state=IDLE (or BOOT_ANF if AUTO_BOOT), all outputs 0, rsp_data=0, timer=0.
//  ru_* outputs registered; param/data_in stable from request through fall of busy.
//  Core handshake per access: REQ asserts ru_write/ru_read until ru_busy=1 (>=1 cycle),
//   then WAIT holds strobes low until ru_busy=0. Timer restarts on entry to REQ and
//   WAIT; reaching BUSY_TO -> ERR. Strobe and busy high same cycle: leave REQ next cycle.
//  Before any REQ, wait in current state while ru_busy=1 (same timeout).
//  BOOT: ANF write(3'b101,24'h1) -> ADDR write(3'b100,addr) -> [WD_EN: TO write
//   (3'b010,WD_TIMEOUT), EN write(3'b011,1)] -> RECONF: ru_reconfig=bootapp for exactly
//   1 cycle -> DONE. From cmd: rsp_valid,rsp_err=0 one cycle after RECONF, ->IDLE.
//   AUTO_BOOT run: no rsp_valid; DONE->IDLE (cmd_ready=1) so later cmds accepted.
//  READ_PARAM: read(cmd_param) handshake; on busy fall latch ru_data_out into rsp_data;
//   rsp_valid next cycle.
//  WD_KICK: ru_rst_timer=1 for 2 cycles, rsp_valid on third; no busy handshake.
//  ERR: drop strobes, rsp_valid=1,rsp_err=1 (AUTO_BOOT: error sticky flag only, silent),
//   -> IDLE. No reconfig after error.
//  cmd_valid outside IDLE ignored (not queued). rst mid-sequence: outputs 0 next cycle,
//   sequence restarts from reset state; partially written params not recovered.
// TESTING
//  AUTO_BOOT=1,bootapp=1, model busy 3 cycles/access -> writes (5,1),(4,040000), one reconfig pulse.
//  AUTO_BOOT=1,bootapp=0 -> same writes, ru_reconfig never asserted, cmd_ready=1 after.
//  WD_EN=1, cmd BOOT addr=24'h080000 -> writes 5,4(080000),2(000100),3(1), rsp_err=0.
//  READ_PARAM param=3'b100, model returns 24'h0ABCDE -> rsp_data=0ABCDE, rsp_valid 1 cycle.
//  Model never raises busy -> after BUSY_TO+1 cycles rsp_err=1, no reconfig, back to IDLE.
//  rst asserted during ADDR WAIT -> all ru_* 0 next cycle; sequence restarts cleanly.

Source files
------------

// File: rtl/remote_update_seq.sv
// remote_update_seq: command sequencer for the remote-update core.
// Boot-address/watchdog writes, parameter reads and watchdog kicks.
module remote_update_seq #(
    parameter logic [23:0] BOOT_ADDR  = 24'h040000,
    parameter bit          AUTO_BOOT  = 1'b1,
    parameter bit          WD_EN      = 1'b0,
    parameter logic [11:0] WD_TIMEOUT = 12'h100,
    parameter int          BUSY_TO    = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_bootapp,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [1:0]  i_cmd_op,
    input  logic [2:0]  i_cmd_param,
    input  logic [23:0] i_cmd_addr,
    output logic        o_rsp_valid,
    output logic        o_rsp_err,
    output logic [23:0] o_rsp_data,
    output logic [2:0]  o_ru_param,
    output logic [23:0] o_ru_data_in,
    output logic        o_ru_write,
    output logic        o_ru_read,
    output logic        o_ru_reconfig,
    output logic        o_ru_rst_timer,
    input  logic        i_ru_busy,
    input  logic [23:0] i_ru_data_out
);
    localparam int TW = $clog2(BUSY_TO + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_REQ, S_WAIT,
        S_RECONF, S_DONE, S_KICK, S_ERR
    } state_t;

    state_t        r_state;
    logic [1:0]    r_step;
    logic          r_is_read;
    logic          r_auto;
    logic          r_auto_err;
    logic          r_kick;
    logic [2:0]    r_rd_param;
    logic [23:0]   r_addr;
    logic [TW-1:0] r_timer;
    logic          r_rsp_valid;
    logic          r_rsp_err;
    logic [23:0]   r_rsp_data;
    logic [2:0]    r_ru_param;
    logic [23:0]   r_ru_data_in;
    logic          r_ru_write;
    logic          r_ru_read;
    logic          r_ru_reconfig;
    logic          r_ru_rst_timer;

    logic [2:0]  w_param;
    logic [23:0] w_data;
    logic        w_last;
    logic        w_to;

    // BOOT step table: ANF, ADDR, then optional watchdog timeout/enable
    always_comb begin
        w_param = r_rd_param;
        w_data  = 24'h0;
        if (!r_is_read) begin
            unique case (r_step)
                2'd0: begin w_param = 3'b101; w_data = 24'h1; end
                2'd1: begin w_param = 3'b100; w_data = r_addr; end
                2'd2: begin w_param = 3'b010; w_data = {12'h0, WD_TIMEOUT}; end
                2'd3: begin w_param = 3'b011; w_data = 24'h1; end
            endcase
        end
    end

    assign w_last = (r_step == (WD_EN ? 2'd3 : 2'd1));
    assign w_to   = (r_timer == TW'(BUSY_TO - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= AUTO_BOOT ? S_SETUP : S_IDLE;
            r_auto         <= AUTO_BOOT;
            r_auto_err     <= 1'b0;
            r_step         <= 2'd0;
            r_is_read      <= 1'b0;
            r_kick         <= 1'b0;
            r_rd_param     <= 3'd0;
            r_addr         <= BOOT_ADDR;
            r_timer        <= '0;
            r_rsp_valid    <= 1'b0;
            r_rsp_err      <= 1'b0;
            r_rsp_data     <= 24'h0;
            r_ru_param     <= 3'd0;
            r_ru_data_in   <= 24'h0;
            r_ru_write     <= 1'b0;
            r_ru_read      <= 1'b0;
            r_ru_reconfig  <= 1'b0;
            r_ru_rst_timer <= 1'b0;
        end else begin
            r_rsp_valid   <= 1'b0;
            r_rsp_err     <= 1'b0;
            r_ru_reconfig <= 1'b0;
            unique case (r_state)
                S_IDLE: if (i_cmd_valid) begin
                    r_auto    <= 1'b0;
                    r_step    <= 2'd0;
                    r_timer   <= '0;
                    r_is_read <= 1'b0;
                    r_kick    <= 1'b0;
                    unique case (i_cmd_op)
                        2'd0: begin
                            r_addr  <= (i_cmd_addr == 24'h0) ? BOOT_ADDR : i_cmd_addr;
                            r_state <= S_SETUP;
                        end
                        2'd1: begin
                            r_is_read  <= 1'b1;
                            r_rd_param <= i_cmd_param;
                            r_state    <= S_SETUP;
                        end
                        2'd2: begin
                            r_ru_rst_timer <= 1'b1;
                            r_state        <= S_KICK;
                        end
                        default: r_state <= S_DONE;
                    endcase
                end
                // hold off the request while the core is still busy
                S_SETUP: begin
                    r_ru_param   <= w_param;
                    r_ru_data_in <= w_data;
                    if (!i_ru_busy) begin
                        r_ru_write <= !r_is_read;
                        r_ru_read  <= r_is_read;
                        r_timer    <= '0;
                        r_state    <= S_REQ;
                    end else if (w_to) begin
                        r_state <= S_ERR;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_REQ: begin
                    if (i_ru_busy) begin
                        r_ru_write <= 1'b0;
                        r_ru_read  <= 1'b0;
                        r_timer    <= '0;
                        r_state    <= S_WAIT;
                    end else if (w_to) begin
                        r_ru_write <= 1'b0;
                        r_ru_read  <= 1'b0;
                        r_state    <= S_ERR;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_WAIT: begin
                    if (!i_ru_busy) begin
                        r_timer <= '0;
                        if (r_is_read) begin
                            r_rsp_data <= i_ru_data_out;
                            r_state    <= S_DONE;
                        end else if (w_last) begin
                            r_state <= S_RECONF;
                        end else begin
                            r_step  <= r_step + 2'd1;
                            r_state <= S_SETUP;
                        end
                    end else if (w_to) begin
                        r_state <= S_ERR;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_RECONF: begin
                    r_ru_reconfig <= i_bootapp;
                    r_state       <= S_DONE;
                end
                S_DONE: begin
                    r_rsp_valid <= !r_auto;
                    if (!r_is_read) r_rsp_data <= 24'h0;
                    r_auto  <= 1'b0;
                    r_state <= S_IDLE;
                end
                S_KICK: begin
                    if (!r_kick) begin
                        r_kick <= 1'b1;
                    end else begin
                        r_ru_rst_timer <= 1'b0;
                        r_rsp_valid    <= 1'b1;
                        r_rsp_data     <= 24'h0;
                        r_state        <= S_IDLE;
                    end
                end
                // power-on boot failures are only remembered, never reported
                S_ERR: begin
                    r_auto_err  <= r_auto_err | r_auto;
                    r_rsp_valid <= !r_auto;
                    r_rsp_err   <= !r_auto;
                    if (!r_auto) r_rsp_data <= 24'h0;
                    r_auto  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_cmd_ready    = (r_state == S_IDLE);
    assign o_rsp_valid    = r_rsp_valid;
    assign o_rsp_err      = r_rsp_err;
    assign o_rsp_data     = r_rsp_data;
    assign o_ru_param     = r_ru_param;
    assign o_ru_data_in   = r_ru_data_in;
    assign o_ru_write     = r_ru_write;
    assign o_ru_read      = r_ru_read;
    assign o_ru_reconfig  = r_ru_reconfig;
    assign o_ru_rst_timer = r_ru_rst_timer;
endmodule

// File: tb/tb_remote_update_seq.sv
// tb_remote_update_seq: bench for remote_update_seq with a behavioural
// remote-update core and an access-list reference model.
module tb_remote_update_seq;
    localparam logic [23:0] P_BOOT = 24'h040000;
    localparam logic [11:0] P_WDT  = 12'h100;
    localparam bit          P_WD   = 1'b1;
    localparam int          P_TO   = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bootapp = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'd0;
    logic [2:0]  cmd_param = 3'd0;
    logic [23:0] cmd_addr = 24'h0;
    logic        cmd_ready, rsp_valid, rsp_err;
    logic [23:0] rsp_data, ru_data_in;
    logic [23:0] ru_data_out = 24'h0;
    logic [2:0]  ru_param;
    logic        ru_write, ru_read, ru_reconfig, ru_rst_timer, ru_busy;

    always #5 clk = ~clk;

    remote_update_seq #(
        .BOOT_ADDR(P_BOOT), .AUTO_BOOT(1'b1), .WD_EN(P_WD),
        .WD_TIMEOUT(P_WDT), .BUSY_TO(P_TO)
    ) dut (
        .clk(clk), .rst(rst), .i_bootapp(bootapp),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_op(cmd_op), .i_cmd_param(cmd_param), .i_cmd_addr(cmd_addr),
        .o_rsp_valid(rsp_valid), .o_rsp_err(rsp_err), .o_rsp_data(rsp_data),
        .o_ru_param(ru_param), .o_ru_data_in(ru_data_in),
        .o_ru_write(ru_write), .o_ru_read(ru_read),
        .o_ru_reconfig(ru_reconfig), .o_ru_rst_timer(ru_rst_timer),
        .i_ru_busy(ru_busy), .i_ru_data_out(ru_data_out)
    );

    // ---------------- behavioural core ----------------
    typedef struct packed {
        logic        rd;
        logic [2:0]  p;
        logic [23:0] d;
    } acc_t;

    acc_t        log_q[$];
    acc_t        exp_q[$];
    acc_t        cur = '0;
    logic        r_busy = 1'b0;
    logic        hold_busy = 1'b0;
    logic        never = 1'b0;
    logic        track = 1'b0;
    logic [23:0] rd_val = 24'h0;
    int          lat = 3;
    int          cnt = 0;
    int          reconf_cnt = 0;
    int          kick_cnt = 0;
    int          rsp_cnt = 0;
    int          unstable = 0;

    assign ru_busy = r_busy | hold_busy;

    always @(posedge clk) begin
        if (ru_reconfig) reconf_cnt <= reconf_cnt + 1;
        if (ru_rst_timer) kick_cnt <= kick_cnt + 1;
        if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
        if (rst) track <= 1'b0;
        else if (track && cnt > 0 &&
                 (ru_param != cur.p || (!cur.rd && ru_data_in != cur.d)))
            unstable <= unstable + 1;
        if (cnt > 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) r_busy <= 1'b0;
        end else if ((ru_write || ru_read) && !ru_busy && !never) begin
            log_q.push_back(acc_t'{ru_read, ru_param, ru_read ? 24'h0 : ru_data_in});
            cur         <= acc_t'{ru_read, ru_param, ru_read ? 24'h0 : ru_data_in};
            track       <= 1'b1;
            cnt         <= lat;
            r_busy      <= 1'b1;
            ru_data_out <= rd_val;
        end
    end

    // ---------------- checking ----------------
    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: the list of core accesses a command must produce
    task automatic build_exp(input logic [1:0] op, input logic [2:0] prm, input logic [23:0] addr);
        exp_q.delete();
        if (op == 2'd0) begin
            exp_q.push_back(acc_t'{1'b0, 3'd5, 24'd1});
            exp_q.push_back(acc_t'{1'b0, 3'd4, (addr == 24'h0) ? P_BOOT : addr});
            if (P_WD) begin
                exp_q.push_back(acc_t'{1'b0, 3'd2, {12'h0, P_WDT}});
                exp_q.push_back(acc_t'{1'b0, 3'd3, 24'd1});
            end
        end else if (op == 2'd1) begin
            exp_q.push_back(acc_t'{1'b1, prm, 24'd0});
        end
    endtask

    task automatic cmp_log(input string tag, input int base);
        check({tag, " nacc"}, log_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (base + i < log_q.size())
                check($sformatf("%s acc%0d", tag, i), 32'(log_q[base + i]), 32'(exp_q[i]));
    endtask

    task automatic wait_ready(input string tag, input int budget);
        for (int i = 0; i < budget && !cmd_ready; i++) begin
            @(posedge clk); #1;
        end
        check({tag, " cmd_ready"}, 32'(cmd_ready), 1);
    endtask

    task automatic issue(input logic [1:0] op, input logic [2:0] prm, input logic [23:0] addr,
                         input bit poke, input int budget,
                         output bit got, output logic err, output logic [23:0] dat, output int cyc);
        got = 0; err = 0; dat = 0; cyc = 0;
        wait_ready("issue", 100);
        cmd_valid = 1'b1; cmd_op = op; cmd_param = prm; cmd_addr = addr;
        @(posedge clk); #1;
        cmd_valid = poke;
        if (poke) begin
            cmd_op = 2'($urandom); cmd_param = 3'($urandom); cmd_addr = 24'($urandom);
        end
        for (int i = 1; i <= budget; i++) begin
            if (rsp_valid) begin
                got = 1; err = rsp_err; dat = rsp_data; cyc = i;
                break;
            end
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        if (got) begin
            @(posedge clk); #1;
            check("rsp_valid one cycle", 32'(rsp_valid), 0);
        end
    endtask

    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [2:0] prm,
                           input logic [23:0] addr, input bit poke, input logic [23:0] e_data,
                           input int e_nacc, input int e_rc, input int e_kick);
        int lb, rb, kb, cyc;
        bit got;
        logic err;
        logic [23:0] dat;
        lb = log_q.size(); rb = reconf_cnt; kb = kick_cnt;
        build_exp(op, prm, addr);
        issue(op, prm, addr, poke, 80, got, err, dat, cyc);
        check({tag, " rsp seen"}, 32'(got), 1);
        check({tag, " rsp_err"}, 32'(err), 0);
        check({tag, " rsp_data"}, 32'(dat), 32'(e_data));
        check({tag, " n accesses"}, log_q.size() - lb, e_nacc);
        cmp_log(tag, lb);
        check({tag, " reconfig"}, reconf_cnt - rb, e_rc);
        check({tag, " rst_timer"}, kick_cnt - kb, e_kick);
    endtask

    task automatic auto_boot_check(input string tag, input int e_rc);
        int lb, rb, sb;
        lb = log_q.size(); rb = reconf_cnt; sb = rsp_cnt;
        rst = 1'b0;
        wait_ready(tag, 300);
        build_exp(2'd0, 3'd0, 24'h0);
        cmp_log(tag, lb);
        check({tag, " reconfig"}, reconf_cnt - rb, e_rc);
        check({tag, " no rsp"}, rsp_cnt - sb, 0);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  prm;
        logic [23:0] addr;
        logic        ba;
        logic [23:0] rdv;
        int          lt;
        logic [23:0] e_data;
        int          e_nacc;
        int          e_rc;
        int          e_kick;
    } vec_t;

    vec_t vt[6];

    initial begin
        bit got;
        logic err;
        logic [23:0] dat;
        int cyc, lb, rb;
        logic [1:0] op;

        vt[0] = '{2'd0, 3'd0, 24'h080000, 1'b1, 24'h0,      3, 24'h0,      4, 1, 0};
        vt[1] = '{2'd1, 3'd4, 24'h0,      1'b1, 24'h0ABCDE, 3, 24'h0ABCDE, 1, 0, 0};
        vt[2] = '{2'd2, 3'd0, 24'h0,      1'b0, 24'h0,      3, 24'h0,      0, 0, 2};
        vt[3] = '{2'd3, 3'd0, 24'h0,      1'b1, 24'h0,      3, 24'h0,      0, 0, 0};
        vt[4] = '{2'd0, 3'd0, 24'h0,      1'b0, 24'h0,      1, 24'h0,      4, 0, 0};
        vt[5] = '{2'd1, 3'd2, 24'h0,      1'b0, 24'hFFFFFF, 1, 24'hFFFFFF, 1, 0, 0};

        // reset state, then power-on boot with bootapp=1
        bootapp = 1'b1; lat = 3; rst = 1'b1;
        @(posedge clk); #1;
        check("reset ru outputs",
              {ru_write, ru_read, ru_reconfig, ru_rst_timer, ru_param, ru_data_in}, 0);
        check("reset rsp", {rsp_valid, rsp_err, rsp_data}, 0);
        check("reset cmd_ready", 32'(cmd_ready), 0);
        @(posedge clk); #1;
        auto_boot_check("auto ba1", 1);

        // power-on boot with bootapp=0
        bootapp = 1'b0; rst = 1'b1;
        @(posedge clk); #1; @(posedge clk); #1;
        auto_boot_check("auto ba0", 0);

        foreach (vt[i]) begin
            bootapp = vt[i].ba; rd_val = vt[i].rdv; lat = vt[i].lt;
            run_cmd($sformatf("vec%0d", i), vt[i].op, vt[i].prm, vt[i].addr, 1'b0,
                    vt[i].e_data, vt[i].e_nacc, vt[i].e_rc, vt[i].e_kick);
        end

        // core never raises busy: timeout error, no reconfig
        never = 1'b1; bootapp = 1'b1;
        lb = log_q.size(); rb = reconf_cnt;
        issue(2'd0, 3'd0, 24'h0, 1'b0, 80, got, err, dat, cyc);
        check("timeout rsp seen", 32'(got), 1);
        check("timeout rsp_err", 32'(err), 1);
        check("timeout latency", 32'(cyc >= P_TO && cyc <= P_TO + 5), 1);
        check("timeout reconfig", reconf_cnt - rb, 0);
        check("timeout no access", log_q.size() - lb, 0);
        never = 1'b0;

        // busy already high before the request: wait, then proceed
        lat = 2; rd_val = 24'h5A5A5A; hold_busy = 1'b1;
        fork
            begin
                repeat (6) @(posedge clk);
                hold_busy = 1'b0;
            end
        join_none
        run_cmd("prebusy", 2'd1, 3'd6, 24'h0, 1'b0, 24'h5A5A5A, 1, 0, 0);

        // busy stuck high before the request: timeout
        hold_busy = 1'b1; lb = log_q.size();
        issue(2'd1, 3'd1, 24'h0, 1'b0, 80, got, err, dat, cyc);
        check("stuck busy rsp seen", 32'(got), 1);
        check("stuck busy rsp_err", 32'(err), 1);
        check("stuck busy no access", log_q.size() - lb, 0);
        hold_busy = 1'b0;

        // reset during the ADDR write busy wait
        lat = 8; bootapp = 1'b1; lb = log_q.size();
        wait_ready("midrst", 100);
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_addr = 24'h123456;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int i = 0; i < 60 && log_q.size() < lb + 2; i++) begin
            @(posedge clk); #1;
        end
        check("midrst addr write", log_q.size() - lb, 2);
        if (log_q.size() >= lb + 2)
            check("midrst addr value", 32'(log_q[lb + 1]), 32'(acc_t'{1'b0, 3'd4, 24'h123456}));
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst ru outputs",
              {ru_write, ru_read, ru_reconfig, ru_rst_timer, ru_param, ru_data_in}, 0);
        check("midrst rsp_valid", 32'(rsp_valid), 0);
        lat = 3;
        auto_boot_check("midrst reboot", 1);

        // randomized commands against the reference model
        for (int n = 0; n < 40; n++) begin
            logic [2:0] prm;
            logic [23:0] addr;
            op = 2'($urandom_range(0, 3));
            prm = 3'($urandom);
            addr = ($urandom_range(0, 3) == 0) ? 24'h0 : 24'($urandom);
            bootapp = 1'($urandom);
            rd_val = 24'($urandom);
            lat = $urandom_range(1, 4);
            build_exp(op, prm, addr);
            run_cmd($sformatf("rnd%0d", n), op, prm, addr, 1'($urandom),
                    (op == 2'd1) ? rd_val : 24'h0, exp_q.size(),
                    (op == 2'd0) ? 32'(bootapp) : 0, (op == 2'd2) ? 2 : 0);
        end

        check("param/data stable during busy", unstable, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
